pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Pipeline control unit for the fetch/decode/execute core. It watches the one-hot opcode entering the execute stage and the branch result leaving it. From these it drives PC/IF-ID/ID-EX enables, bubble injection and flushes. It also sequences the shared multi-cycle multiplier (MUL, 16'h1000), holds the pipeline on HLT (16'h2000), and keeps a saturating stall-cycle counter for performance debug.

## Interface
- MUL_CYCLES, 4, multiplier latency in cycles; legal range 1..15
- FLUSH_SLOTS, 2, bubbles injected after a taken branch; legal range 1..15
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- ex_valid  in  1  ID/EX holds a live instruction
- ex_opcode  in  16  one-hot opcode of the ID/EX instruction
- branch_taken  in  1  execute stage resolved a taken branch this cycle
- resume  in  1  leave HALT
- pc_write_en  out  1  PC may update
- if_id_write_en  out  1  IF/ID may load
- if_id_flush  out  1  IF/ID loads NOP
- id_ex_hold  out  1  ID/EX keeps its contents
- id_ex_bubble  out  1  ID/EX loads NOP (16'h4000)
- mul_start  out  1  one-cycle start pulse to the multiplier
- mul_busy  out  1  multiplier occupied
- halted  out  1  controller in HALT
- illegal_op  out  1  sticky flag for an illegal opcode
- stall_cycles  out  16  saturating count of cycles with pc_write_en=0

## Operation
- States: RUN, MUL_WAIT, FLUSH, HALT. One 4-bit down-counter `cnt` is shared by MUL_WAIT and FLUSH.
- Control outputs are combinational from state plus the current inputs. State, `cnt`, illegal_op and stall_cycles are registered.
- Opcode decode applies only when ex_valid=1.
- RUN, with inputs checked in this priority order:
  - **branch_taken=1:** if_id_flush=1, id_ex_bubble=1, pc_write_en=1. If FLUSH_SLOTS>1, go to FLUSH with cnt=FLUSH_SLOTS-2; otherwise stay in RUN.
  - **HLT:** pc_write_en=0, if_id_write_en=0, id_ex_bubble=1. Next state HALT.
  - **MUL:** mul_start=1. If MUL_CYCLES>1: pc_write_en=0, if_id_write_en=0, id_ex_hold=1, cnt=MUL_CYCLES-2, next state MUL_WAIT. If MUL_CYCLES=1: no stall, stay in RUN.
  - **ex_opcode not exactly one-hot:** set illegal_op. Otherwise the instruction is treated as a NOP; no stall.
  - **Otherwise:** pc_write_en=1 and if_id_write_en=1; all other controls 0.
- MUL_WAIT:
  - mul_busy=1, pc_write_en=0, if_id_write_en=0, id_ex_hold=1.
  - If cnt=0, release all stalls in this same cycle (pc/if_id enabled, hold=0) and return to RUN. Otherwise decrement cnt.
  - branch_taken and a repeated MUL decode are ignored in this state.
- FLUSH:
  - if_id_flush=1, id_ex_bubble=1, pc_write_en=1.
  - If cnt=0, go to RUN; otherwise decrement cnt.
  - A new branch_taken reloads cnt=FLUSH_SLOTS-2 (or returns to RUN if FLUSH_SLOTS=1).
- HALT:
  - pc_write_en=0, if_id_write_en=0, id_ex_bubble=1, halted=1.
  - resume=1 moves to RUN next cycle; all other inputs are ignored.
- illegal_op: cleared only by reset.
- stall_cycles: increments on every edge where pc_write_en=0 and saturates at 16'hFFFF.

## Timing
- Reset (async assert, sync release): state=RUN, cnt=0, illegal_op=0, stall_cycles=0.
- Output values while reset is held and ex_valid=0: pc_write_en=1 and if_id_write_en=1; all other outputs 0.
- MUL stall: pc_write_en is low for exactly MUL_CYCLES-1 consecutive cycles, starting with the cycle MUL is decoded. The pipeline advances on the MUL_CYCLES-th cycle. mul_busy is high for MUL_CYCLES-1 cycles, from the cycle after mul_start.
- Branch: exactly FLUSH_SLOTS consecutive cycles with id_ex_bubble=1, starting with the branch_taken cycle.
- HLT: halted rises the cycle after decode. After resume=1 is sampled, pc_write_en=1 in the following cycle.
- Reset asserted mid-MUL_WAIT, FLUSH or HALT returns immediately to RUN defaults. No mul_start is reissued.

## Test plan
- **MUL stall, MUL_CYCLES=4:** ex_valid=1, ex_opcode=16'h1000 for one cycle.
  - mul_start high 1 cycle; pc_write_en low 3 cycles; mul_busy high 3 cycles.
  - stall_cycles=3; RUN afterwards.
- **Taken branch, FLUSH_SLOTS=2:** branch_taken pulse with opcode 16'h0001.
  - id_ex_bubble and if_id_flush high 2 cycles; pc_write_en stays 1; no stall counted.
- **Simultaneous branch_taken and MUL in RUN:** flush wins; mul_start=0; state FLUSH.
- **HLT then resume:** ex_opcode=16'h2000 leads to halted=1 and pc_write_en=0 for N cycles. A resume pulse gives halted=0 and pc_write_en=1 the next cycle; stall_cycles=N+1.
- **Illegal opcode:** ex_opcode=16'h0003 with ex_valid=1.
  - illegal_op=1 and stays 1 through further legal ops; no stall.
  - ex_opcode=16'h0003 with ex_valid=0 leaves illegal_op=0.
- **Reset mid-MUL_WAIT, plus saturation:** reset_n low asynchronously gives pc_write_en=1 and mul_busy=0 before the next edge. Forcing 70000 halted cycles leaves stall_cycles=16'hFFFF.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: drives PC/IF-ID/ID-EX enables, flushes and bubbles,
// sequences the shared multi-cycle multiplier and holds the pipeline on HLT.
`timescale 1ns/1ps
module pipeline_ctrl #(
  parameter int unsigned MUL_CYCLES  = 4,
  parameter int unsigned FLUSH_SLOTS = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ex_valid,
  input  logic [15:0] ex_opcode,
  input  logic        branch_taken,
  input  logic        resume,
  output logic        pc_write_en,
  output logic        if_id_write_en,
  output logic        if_id_flush,
  output logic        id_ex_hold,
  output logic        id_ex_bubble,
  output logic        mul_start,
  output logic        mul_busy,
  output logic        halted,
  output logic        illegal_op,
  output logic [15:0] stall_cycles
);

  localparam logic [15:0] OpMul = 16'h1000;
  localparam logic [15:0] OpHlt = 16'h2000;

  // The decode/branch cycle itself is the first stall or bubble cycle, hence the -2 reloads.
  localparam bit       MulStalls  = (MUL_CYCLES > 1);
  localparam bit       FlushMulti = (FLUSH_SLOTS > 1);
  localparam logic [3:0] MulLoad   = MulStalls  ? 4'(MUL_CYCLES - 2)  : 4'd0;
  localparam logic [3:0] FlushLoad = FlushMulti ? 4'(FLUSH_SLOTS - 2) : 4'd0;

  typedef enum logic [1:0] {StRun, StMulWait, StFlush, StHalt} state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       illegal_set;
  logic       dec_mul, dec_hlt, op_onehot;

  assign dec_mul   = ex_valid && (ex_opcode == OpMul);
  assign dec_hlt   = ex_valid && (ex_opcode == OpHlt);
  assign op_onehot = (ex_opcode != '0) && ((ex_opcode & (ex_opcode - 16'd1)) == '0);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    pc_write_en    = 1'b1;
    if_id_write_en = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_hold     = 1'b0;
    id_ex_bubble   = 1'b0;
    mul_start      = 1'b0;
    mul_busy       = 1'b0;
    halted         = 1'b0;
    illegal_set    = 1'b0;

    unique case (state_q)
      StRun: begin
        if (branch_taken) begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          if (FlushMulti) begin
            state_d = StFlush;
            cnt_d   = FlushLoad;
          end
        end else if (dec_hlt) begin
          pc_write_en    = 1'b0;
          if_id_write_en = 1'b0;
          id_ex_bubble   = 1'b1;
          state_d        = StHalt;
        end else if (dec_mul) begin
          mul_start = 1'b1;
          if (MulStalls) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            id_ex_hold     = 1'b1;
            cnt_d          = MulLoad;
            state_d        = StMulWait;
          end
        end else if (ex_valid && !op_onehot) begin
          illegal_set = 1'b1;
        end
      end

      StMulWait: begin
        mul_busy = 1'b1;
        // Final multiplier cycle releases the pipeline so the result is consumed immediately.
        if (cnt_q == 4'd0) begin
          state_d = StRun;
        end else begin
          pc_write_en    = 1'b0;
          if_id_write_en = 1'b0;
          id_ex_hold     = 1'b1;
          cnt_d          = cnt_q - 4'd1;
        end
      end

      StFlush: begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        if (branch_taken) begin
          if (FlushMulti) cnt_d = FlushLoad;
          else            state_d = StRun;
        end else if (cnt_q == 4'd0) begin
          state_d = StRun;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      StHalt: begin
        pc_write_en    = 1'b0;
        if_id_write_en = 1'b0;
        id_ex_bubble   = 1'b1;
        halted         = 1'b1;
        if (resume) state_d = StRun;
      end

      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StRun;
      cnt_q        <= '0;
      illegal_op   <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (illegal_set) illegal_op <= 1'b1;
      if (!pc_write_en && (stall_cycles != 16'hFFFF)) stall_cycles <= stall_cycles + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized traffic,
// all compared against a cycle-budget reference model of the control rules.
`timescale 1ns/1ps
module tb_pipeline_ctrl;

  localparam int unsigned MUL_CYCLES  = 4;
  localparam int unsigned FLUSH_SLOTS = 2;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic [15:0] ex_opcode = '0;
  logic        branch_taken = 1'b0;
  logic        resume = 1'b0;
  logic        pc_write_en, if_id_write_en, if_id_flush, id_ex_hold, id_ex_bubble;
  logic        mul_start, mul_busy, halted, illegal_op;
  logic [15:0] stall_cycles;
  logic [7:0]  obs;

  int checks = 0;
  int errors = 0;

  // Reference model: remaining cycles of each activity rather than an FSM encoding.
  int m_busy_left  = 0;
  int m_flush_left = 0;
  bit m_halt       = 1'b0;
  bit m_illegal    = 1'b0;
  int m_stalls     = 0;

  pipeline_ctrl #(
    .MUL_CYCLES (MUL_CYCLES),
    .FLUSH_SLOTS(FLUSH_SLOTS)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .ex_valid      (ex_valid),
    .ex_opcode     (ex_opcode),
    .branch_taken  (branch_taken),
    .resume        (resume),
    .pc_write_en   (pc_write_en),
    .if_id_write_en(if_id_write_en),
    .if_id_flush   (if_id_flush),
    .id_ex_hold    (id_ex_hold),
    .id_ex_bubble  (id_ex_bubble),
    .mul_start     (mul_start),
    .mul_busy      (mul_busy),
    .halted        (halted),
    .illegal_op    (illegal_op),
    .stall_cycles  (stall_cycles)
  );

  assign obs = {pc_write_en, if_id_write_en, if_id_flush, id_ex_hold,
                id_ex_bubble, mul_start, mul_busy, halted};

  always #5 clock = ~clock;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected {pc, ifid_we, flush, hold, bubble, start, busy, halted} for this cycle.
  function automatic logic [7:0] model_out();
    logic pc, ifid, fl, hd, bb, st, by, ht;
    pc = 1; ifid = 1; fl = 0; hd = 0; bb = 0; st = 0; by = 0; ht = 0;
    if (m_busy_left > 0) begin
      by = 1;
      if (m_busy_left > 1) begin pc = 0; ifid = 0; hd = 1; end
    end else if (m_flush_left > 0) begin
      fl = 1; bb = 1;
    end else if (m_halt) begin
      pc = 0; ifid = 0; bb = 1; ht = 1;
    end else if (branch_taken) begin
      fl = 1; bb = 1;
    end else if (ex_valid && ex_opcode == 16'h2000) begin
      pc = 0; ifid = 0; bb = 1;
    end else if (ex_valid && ex_opcode == 16'h1000) begin
      st = 1;
      if (MUL_CYCLES > 1) begin pc = 0; ifid = 0; hd = 1; end
    end
    return {pc, ifid, fl, hd, bb, st, by, ht};
  endfunction

  function automatic void model_edge();
    logic [7:0] e;
    e = model_out();
    if (!e[7] && m_stalls < 65535) m_stalls++;
    if (m_busy_left > 0) begin
      m_busy_left--;
    end else if (m_flush_left > 0) begin
      if (branch_taken) m_flush_left = int'(FLUSH_SLOTS) - 1;
      else              m_flush_left--;
    end else if (m_halt) begin
      if (resume) m_halt = 1'b0;
    end else if (branch_taken) begin
      m_flush_left = int'(FLUSH_SLOTS) - 1;
    end else if (ex_valid && ex_opcode == 16'h2000) begin
      m_halt = 1'b1;
    end else if (ex_valid && ex_opcode == 16'h1000) begin
      m_busy_left = int'(MUL_CYCLES) - 1;
    end else if (ex_valid && $countones(ex_opcode) != 1) begin
      m_illegal = 1'b1;
    end
  endfunction

  function automatic void model_reset();
    m_busy_left = 0; m_flush_left = 0; m_halt = 0; m_illegal = 0; m_stalls = 0;
  endfunction

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic set_idle();
    ex_valid = 0; ex_opcode = '0; branch_taken = 0; resume = 0;
  endtask

  task automatic test_reset();
    set_idle();
    reset_n = 0;
    #3;
    checks++;
    if (obs !== 8'b1100_0000) begin
      errors++; $display("FAIL reset_outputs: got %b want %b", obs, 8'b1100_0000);
    end
    @(posedge clock); #1;
    checks++;
    if (stall_cycles !== 16'd0 || illegal_op !== 1'b0) begin
      errors++; $display("FAIL reset_regs: got stall=%0d ill=%b want 0/0", stall_cycles, illegal_op);
    end
    @(negedge clock);
    reset_n = 1;
    model_reset();
    tick();
  endtask

  task automatic test_mul();
    int pc_low = 0, busy_hi = 0, starts = 0, base;
    base = m_stalls;
    ex_valid = 1; ex_opcode = 16'h1000;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      checks++;
      if (obs !== model_out()) begin
        errors++; $display("FAIL mul_cycle%0d: got %b want %b", c, obs, model_out());
      end
      if (!pc_write_en) pc_low++;
      if (mul_busy) busy_hi++;
      if (mul_start) starts++;
      tick();
      ex_valid = 0; ex_opcode = '0;
    end
    checks++;
    if (pc_low != 3 || busy_hi != 3 || starts != 1) begin
      errors++; $display("FAIL mul_counts: got pc_low=%0d busy=%0d start=%0d want 3/3/1",
                         pc_low, busy_hi, starts);
    end
    checks++;
    if (stall_cycles !== 16'(base + 3)) begin
      errors++; $display("FAIL mul_stall_cycles: got %0d want %0d", stall_cycles, base + 3);
    end
  endtask

  task automatic test_branch();
    int bubbles = 0, flushes = 0, pc_low = 0, base;
    base = m_stalls;
    ex_valid = 1; ex_opcode = 16'h0001; branch_taken = 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      checks++;
      if (obs !== model_out()) begin
        errors++; $display("FAIL branch_cycle%0d: got %b want %b", c, obs, model_out());
      end
      if (id_ex_bubble) bubbles++;
      if (if_id_flush) flushes++;
      if (!pc_write_en) pc_low++;
      tick();
      set_idle();
    end
    checks++;
    if (bubbles != 2 || flushes != 2 || pc_low != 0) begin
      errors++; $display("FAIL branch_counts: got bubble=%0d flush=%0d pc_low=%0d want 2/2/0",
                         bubbles, flushes, pc_low);
    end
    checks++;
    if (stall_cycles !== 16'(base)) begin
      errors++; $display("FAIL branch_stall_cycles: got %0d want %0d", stall_cycles, base);
    end
  endtask

  task automatic test_branch_mul();
    ex_valid = 1; ex_opcode = 16'h1000; branch_taken = 1;
    @(negedge clock);
    checks++;
    if (mul_start !== 1'b0 || if_id_flush !== 1'b1 || pc_write_en !== 1'b1) begin
      errors++; $display("FAIL branch_vs_mul: got start=%b flush=%b pc=%b want 0/1/1",
                         mul_start, if_id_flush, pc_write_en);
    end
    tick();
    set_idle();
    @(negedge clock);
    checks++;
    if (if_id_flush !== 1'b1 || id_ex_bubble !== 1'b1 || mul_busy !== 1'b0) begin
      errors++; $display("FAIL branch_vs_mul_flush_state: got flush=%b bubble=%b busy=%b want 1/1/0",
                         if_id_flush, id_ex_bubble, mul_busy);
    end
    tick();
    @(negedge clock);
    checks++;
    if (obs !== model_out()) begin
      errors++; $display("FAIL branch_vs_mul_after: got %b want %b", obs, model_out());
    end
    tick();
  endtask

  task automatic test_halt();
    int n = 5, halt_cnt = 0, pc_low = 0, base;
    base = m_stalls;
    ex_valid = 1; ex_opcode = 16'h2000;
    for (int c = 0; c <= n; c++) begin
      resume = (c == n);
      @(negedge clock);
      checks++;
      if (obs !== model_out()) begin
        errors++; $display("FAIL halt_cycle%0d: got %b want %b", c, obs, model_out());
      end
      if (halted) halt_cnt++;
      if (!pc_write_en) pc_low++;
      tick();
      ex_valid = 0; ex_opcode = '0;
    end
    resume = 0;
    @(negedge clock);
    checks++;
    if (halted !== 1'b0 || pc_write_en !== 1'b1 || halt_cnt != n || pc_low != n + 1) begin
      errors++; $display("FAIL halt_resume: got halted=%b pc=%b hcnt=%0d pc_low=%0d want 0/1/%0d/%0d",
                         halted, pc_write_en, halt_cnt, pc_low, n, n + 1);
    end
    checks++;
    if (stall_cycles !== 16'(base + n + 1)) begin
      errors++; $display("FAIL halt_stall_cycles: got %0d want %0d", stall_cycles, base + n + 1);
    end
    tick();
  endtask

  task automatic test_illegal();
    ex_valid = 0; ex_opcode = 16'h0003;
    tick();
    checks++;
    if (illegal_op !== 1'b0) begin
      errors++; $display("FAIL illegal_invalid: got %b want 0", illegal_op);
    end
    ex_valid = 1;
    @(negedge clock);
    checks++;
    if (pc_write_en !== 1'b1 || id_ex_hold !== 1'b0) begin
      errors++; $display("FAIL illegal_no_stall: got pc=%b hold=%b want 1/0", pc_write_en, id_ex_hold);
    end
    tick();
    for (int c = 0; c < 3; c++) begin
      ex_opcode = 16'(32'd1 << c);
      @(negedge clock);
      checks++;
      if (illegal_op !== 1'b1) begin
        errors++; $display("FAIL illegal_sticky%0d: got %b want 1", c, illegal_op);
      end
      tick();
    end
    set_idle();
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 400; i++) begin
      branch_taken = ($urandom_range(0, 99) < 15);
      resume       = ($urandom_range(0, 99) < 25);
      ex_valid     = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 99);
      if (r < 20)      ex_opcode = 16'h1000;
      else if (r < 30) ex_opcode = 16'h2000;
      else if (r < 80) ex_opcode = 16'(32'd1 << $urandom_range(0, 15));
      else             ex_opcode = 16'($urandom);
      @(negedge clock);
      checks++;
      if (obs !== model_out()) begin
        errors++; $display("FAIL random%0d_outputs: got %b want %b (op=%h v=%b br=%b)",
                           i, obs, model_out(), ex_opcode, ex_valid, branch_taken);
      end
      checks++;
      if (stall_cycles !== 16'(m_stalls) || illegal_op !== m_illegal) begin
        errors++; $display("FAIL random%0d_regs: got stall=%0d ill=%b want %0d/%b",
                           i, stall_cycles, illegal_op, m_stalls, m_illegal);
      end
      tick();
    end
    set_idle();
  endtask

  task automatic test_reset_mid_mul();
    resume = 1;
    repeat (20) tick();
    resume = 0;
    ex_valid = 1; ex_opcode = 16'h1000;
    tick();
    set_idle();
    #2;
    reset_n = 0;
    #1;
    checks++;
    if (pc_write_en !== 1'b1 || mul_busy !== 1'b0 || mul_start !== 1'b0) begin
      errors++; $display("FAIL reset_mid_mul: got pc=%b busy=%b start=%b want 1/0/0",
                         pc_write_en, mul_busy, mul_start);
    end
    checks++;
    if (stall_cycles !== 16'd0 || illegal_op !== 1'b0) begin
      errors++; $display("FAIL reset_mid_mul_regs: got stall=%0d ill=%b want 0/0",
                         stall_cycles, illegal_op);
    end
    model_reset();
    @(negedge clock);
    reset_n = 1;
    for (int c = 0; c < 4; c++) begin
      tick();
      @(negedge clock);
      checks++;
      if (mul_start !== 1'b0 || obs !== model_out()) begin
        errors++; $display("FAIL post_reset%0d: got %b want %b", c, obs, model_out());
      end
    end
  endtask

  task automatic test_saturation();
    ex_valid = 1; ex_opcode = 16'h2000;
    tick();
    set_idle();
    repeat (70000) tick();
    @(negedge clock);
    checks++;
    if (stall_cycles !== 16'hFFFF || halted !== 1'b1) begin
      errors++; $display("FAIL saturation: got stall=%h halted=%b want ffff/1", stall_cycles, halted);
    end
    resume = 1;
    tick();
    resume = 0;
    tick();
    @(negedge clock);
    checks++;
    if (stall_cycles !== 16'hFFFF || halted !== 1'b0 || stall_cycles !== 16'(m_stalls)) begin
      errors++; $display("FAIL saturation_hold: got stall=%h halted=%b want ffff/0", stall_cycles, halted);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_branch();
    test_branch_mul();
    test_halt();
    test_illegal();
    test_random();
    test_reset_mid_mul();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
